// File: rtl/axi_loopback_pkg.sv
// Shared types and constants for the AXI4 master/RAM loopback fixture.
// Channel structs are sized by the package widths, which the top-level parameters default to.
package axi_loopback_pkg;

  localparam int AXI_DATA_WIDTH = 256;
  localparam int AXI_ADDR_WIDTH = 12;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] AXI_SIZE_FULL   = 3'($clog2(AXI_STRB_WIDTH));

  localparam logic [31:0] PATTERN_BASE = 32'hA5A5_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } axi_aw_t;

  typedef axi_aw_t axi_ar_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } axi_r_t;

  // Beat i carries PATTERN_BASE + i in every 32-bit lane.
  function automatic logic [AXI_DATA_WIDTH-1:0] beat_pattern(input logic [7:0] beat);
    logic [AXI_DATA_WIDTH-1:0] data;
    for (int l = 0; l < AXI_DATA_WIDTH / 32; l++) begin
      data[32*l +: 32] = PATTERN_BASE + {24'd0, beat};
    end
    return data;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/axi_loopback_ram.sv
// AXI4 RAM slave: one outstanding write and one outstanding read burst, WSTRB honoured.
// AXI_LOOPBACK_BACKPRESSURE_EN makes WREADY/RVALID toggle every cycle inside a burst.
module axi_loopback_ram
  import axi_loopback_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    aw_valid,
  output logic    aw_ready,
  input  axi_aw_t aw,
  input  logic    w_valid,
  output logic    w_ready,
  input  axi_w_t  w,
  output logic    b_valid,
  input  logic    b_ready,
  output axi_b_t  b,
  input  logic    ar_valid,
  output logic    ar_ready,
  input  axi_ar_t ar,
  output logic    r_valid,
  input  logic    r_ready,
  output axi_r_t  r
);

`ifdef AXI_LOOPBACK_BACKPRESSURE_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam int OFFS  = $clog2(AXI_STRB_WIDTH);
  localparam int WORDS = 1 << (AXI_ADDR_WIDTH - OFFS);

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [WORDS];

  wr_state_t  wr_state;
  rd_state_t  rd_state;
  axi_aw_t    wr_cmd;
  axi_ar_t    rd_cmd;
  logic [7:0] rd_cnt;
  logic       wr_stall;
  logic       rd_stall;
  logic       unused_bits;

  // The captured command's addr field doubles as the running beat address.
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input axi_aw_t cmd);
    if (cmd.burst == AXI_BURST_INCR) return cmd.addr + (AXI_ADDR_WIDTH'(1) << cmd.size);
    return cmd.addr;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state <= WR_IDLE;
      aw_ready <= 1'b0;
      wr_cmd   <= '0;
      wr_stall <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_valid && aw_ready) begin
            wr_cmd   <= aw;
            aw_ready <= 1'b0;
            wr_stall <= 1'b0;
            wr_state <= WR_DATA;
          end else begin
            aw_ready <= 1'b1;
          end
        end
        WR_DATA: begin
          wr_stall <= STALL_EN && !wr_stall;
          if (w_valid && w_ready) begin
            wr_cmd.addr <= next_addr(wr_cmd);
            if (w.last) wr_state <= WR_RESP;
          end
        end
        WR_RESP: if (b_ready) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; only control state is reset.
  always_ff @(posedge clock) begin
    if (w_valid && w_ready) begin
      for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
        if (w.strb[i]) mem[wr_cmd.addr[AXI_ADDR_WIDTH-1:OFFS]][8*i +: 8] <= w.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state <= RD_IDLE;
      ar_ready <= 1'b0;
      rd_cmd   <= '0;
      rd_cnt   <= '0;
      rd_stall <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_valid && ar_ready) begin
            rd_cmd   <= ar;
            rd_cnt   <= '0;
            ar_ready <= 1'b0;
            rd_stall <= 1'b0;
            rd_state <= RD_DATA;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        RD_DATA: begin
          rd_stall <= STALL_EN && !rd_stall;
          if (r_valid && r_ready) begin
            if (r.last) begin
              rd_state <= RD_IDLE;
            end else begin
              rd_cmd.addr <= next_addr(rd_cmd);
              rd_cnt      <= rd_cnt + 8'd1;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign w_ready = (wr_state == WR_DATA) && !wr_stall;
  assign b_valid = (wr_state == WR_RESP);
  assign b.id    = wr_cmd.id;
  assign b.resp  = AXI_RESP_OKAY;

  assign r_valid = (rd_state == RD_DATA) && !rd_stall;
  assign r.id    = rd_cmd.id;
  assign r.data  = mem[rd_cmd.addr[AXI_ADDR_WIDTH-1:OFFS]];
  assign r.resp  = AXI_RESP_OKAY;
  assign r.last  = (rd_cnt == rd_cmd.len);

  // Writes end on WLAST, and sub-word address bits never select a row.
  assign unused_bits = ^{wr_cmd.len, wr_cmd.addr[OFFS-1:0], rd_cmd.addr[OFFS-1:0]};

endmodule

// File: rtl/axi_master_ram_loopback.sv
// Test-pattern AXI4 master that writes one INCR burst to an internal RAM and checks it on readback.
// Define AXI_LOOPBACK_BACKPRESSURE_EN to make the RAM stall every other burst cycle.
module axi_master_ram_loopback
  import axi_loopback_pkg::*;
#(
  parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                    ID_WIDTH   = AXI_ID_WIDTH,
  parameter int                    BURST_LEN  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h040
) (
  input  logic       clock,
  input  logic       reset,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_count
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t  state, state_nxt;
  logic    aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic    ar_valid, ar_ready, r_valid, r_ready;
  axi_aw_t aw;
  axi_ar_t ar;
  axi_w_t  w;
  axi_b_t  b;
  axi_r_t  r;

  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            w_beat, r_beat;
  logic [4:0]            err_cnt;
  logic                  r_bad;
  logic                  unused_ids;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      w_beat  <= '0;
      r_beat  <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (w_valid && w_ready) w_beat <= w_beat + 8'd1;
      if (r_valid && r_ready) r_beat <= r_beat + 8'd1;
      if ((b_valid && b_ready && b.resp != AXI_RESP_OKAY) || (r_valid && r_ready && r_bad))
        err_cnt <= sat_inc(err_cnt);
    end
  end

  // VALIDs decode from state only, so they never depend combinationally on READY.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_nxt = state;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_AW;
      ST_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_nxt = ST_W;
      end
      ST_W: begin
        w_valid = 1'b1;
        if (w_ready && w.last) state_nxt = ST_B;
      end
      ST_B: begin
        b_ready = 1'b1;
        if (b_valid) state_nxt = ST_AR;
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (r_valid && r.last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    aw       = '0;
    aw.id    = ID_WIDTH'(0);
    aw.addr  = BASE_ADDR;
    aw.len   = LAST_BEAT;
    aw.size  = AXI_SIZE_FULL;
    aw.burst = AXI_BURST_INCR;
    w.data   = beat_pattern(w_beat);
    w.strb   = '1;
    w.last   = (w_beat == LAST_BEAT);
  end

  assign ar     = aw;
  assign r_data = r.data;
  assign r_bad  = (r_data != beat_pattern(r_beat)) || (r.resp != AXI_RESP_OKAY) ||
                  (r.last != (r_beat == LAST_BEAT));

  assign done           = (state == ST_DONE);
  assign pass           = done && (err_cnt == 5'd0);
  assign mismatch_count = err_cnt;

  // Only ID 0 is ever issued, so returned IDs carry no information.
  assign unused_ids = ^{b.id, r.id};

  axi_loopback_ram u_ram (
    .clock    (clock),
    .reset    (reset),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .aw       (aw),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w        (w),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b        (b),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .ar       (ar),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r        (r)
  );

endmodule

// File: tb/tb_axi_master_ram_loopback.sv
// Directed bench for axi_master_ram_loopback: default 4-beat instance plus a BURST_LEN=1 instance.
// Also builds with AXI_LOOPBACK_BACKPRESSURE_EN, which relaxes the completion bound to 40 cycles.
module tb_axi_master_ram_loopback;
  import axi_loopback_pkg::*;

`ifdef AXI_LOOPBACK_BACKPRESSURE_EN
  localparam int DONE_LIMIT = 40;
`else
  localparam int DONE_LIMIT = 20;
`endif
  localparam int BASE_WORD = 'h040 / 32;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       reset1 = 1'b0;
  logic       done, pass, done1, pass1;
  logic [4:0] mismatch_count, count1;

  int n_compared = 0;
  int n_mismatched = 0;
  int proto_viol = 0;
  int w1_beats = 0, w1_lasts = 0, r1_beats = 0, r1_lasts = 0;

  always #5 clock = ~clock;

  axi_master_ram_loopback #(
    .DATA_WIDTH(256), .ADDR_WIDTH(12), .ID_WIDTH(4), .BURST_LEN(4), .BASE_ADDR(12'h040)
  ) u_dut (
    .clock(clock), .reset(reset), .done(done), .pass(pass), .mismatch_count(mismatch_count)
  );

  axi_master_ram_loopback #(
    .DATA_WIDTH(256), .ADDR_WIDTH(12), .ID_WIDTH(4), .BURST_LEN(1), .BASE_ADDR(12'h040)
  ) u_dut1 (
    .clock(clock), .reset(reset1), .done(done1), .pass(pass1), .mismatch_count(count1)
  );

  // VALID must hold with a stable payload until READY, on every channel of the 4-beat instance.
  logic    prev_rst = 1'b0;
  logic    p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  axi_aw_t p_aw, p_ar;
  axi_w_t  p_w;
  axi_b_t  p_b;
  axi_r_t  p_r;

  always @(negedge clock) begin
    if (reset && prev_rst) begin
      if (p_awv && !p_awr && (!u_dut.aw_valid || u_dut.aw !== p_aw)) begin
        proto_viol++; $display("FAIL proto_aw: valid=%b held payload changed or dropped", u_dut.aw_valid);
      end
      if (p_wv && !p_wr && (!u_dut.w_valid || u_dut.w !== p_w)) begin
        proto_viol++; $display("FAIL proto_w: valid=%b held payload changed or dropped", u_dut.w_valid);
      end
      if (p_bv && !p_br && (!u_dut.b_valid || u_dut.b !== p_b)) begin
        proto_viol++; $display("FAIL proto_b: valid=%b held payload changed or dropped", u_dut.b_valid);
      end
      if (p_arv && !p_arr && (!u_dut.ar_valid || u_dut.ar !== p_ar)) begin
        proto_viol++; $display("FAIL proto_ar: valid=%b held payload changed or dropped", u_dut.ar_valid);
      end
      if (p_rv && !p_rr && (!u_dut.r_valid || u_dut.r !== p_r)) begin
        proto_viol++; $display("FAIL proto_r: valid=%b held payload changed or dropped", u_dut.r_valid);
      end
    end
    prev_rst = reset;
    p_awv = u_dut.aw_valid; p_awr = u_dut.aw_ready; p_aw = u_dut.aw;
    p_wv  = u_dut.w_valid;  p_wr  = u_dut.w_ready;  p_w  = u_dut.w;
    p_bv  = u_dut.b_valid;  p_br  = u_dut.b_ready;  p_b  = u_dut.b;
    p_arv = u_dut.ar_valid; p_arr = u_dut.ar_ready; p_ar = u_dut.ar;
    p_rv  = u_dut.r_valid;  p_rr  = u_dut.r_ready;  p_r  = u_dut.r;
  end

  always @(negedge clock) begin
    if (reset1) begin
      if (u_dut1.w_valid && u_dut1.w_ready) begin
        w1_beats++;
        if (u_dut1.w.last) w1_lasts++;
      end
      if (u_dut1.r_valid && u_dut1.r_ready) begin
        r1_beats++;
        if (u_dut1.r.last) r1_lasts++;
      end
    end
  end

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < DONE_LIMIT) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_compared++;
    if ({done, pass, mismatch_count} !== 7'd0) begin
      n_mismatched++; $display("FAIL reset_outputs: got %b expected 0000000", {done, pass, mismatch_count});
    end
    n_compared++;
    if ({u_dut.aw_valid, u_dut.aw_ready, u_dut.w_valid, u_dut.w_ready, u_dut.b_valid, u_dut.b_ready,
         u_dut.ar_valid, u_dut.ar_ready, u_dut.r_valid, u_dut.r_ready} !== 10'd0) begin
      n_mismatched++; $display("FAIL reset_handshakes: some VALID/READY high during reset");
    end
    n_compared++;
    if (u_dut.state !== ST_IDLE) begin
      n_mismatched++; $display("FAIL reset_state: got %0d expected %0d", u_dut.state, ST_IDLE);
    end
    n_compared++;
    if ({done1, pass1, count1} !== 7'd0) begin
      n_mismatched++; $display("FAIL reset_outputs_len1: got %b expected 0000000", {done1, pass1, count1});
    end
    #8;
    reset  = 1'b1;
    reset1 = 1'b1;
  endtask

  task automatic test_loopback();
    int cycles;
    wait_done(cycles);
    n_compared++;
    if (done !== 1'b1) begin
      n_mismatched++; $display("FAIL done_latency: done=%b after %0d cycles, required 1 within %0d", done, cycles, DONE_LIMIT);
    end
    n_compared++;
    if (pass !== 1'b1 || mismatch_count !== 5'd0) begin
      n_mismatched++; $display("FAIL loopback_result: pass=%b count=%0d expected pass=1 count=0", pass, mismatch_count);
    end
    while ($time < 1000) @(negedge clock);
    n_compared++;
    if ({done, pass, mismatch_count} !== 7'b11_00000) begin
      n_mismatched++; $display("FAIL stable_1000ns: got %b expected 1100000", {done, pass, mismatch_count});
    end
  endtask

  task automatic test_ram_probe();
    logic [255:0] exp3, exp0;
    for (int l = 0; l < 8; l++) begin
      exp3[32*l +: 32] = 32'hA5A5_0003;
      exp0[32*l +: 32] = 32'hA5A5_0000;
    end
    n_compared++;
    if (u_dut.u_ram.mem[BASE_WORD + 3] !== exp3) begin
      n_mismatched++; $display("FAIL ram_word3: got %h expected %h", u_dut.u_ram.mem[BASE_WORD + 3], exp3);
    end
    n_compared++;
    if (u_dut.u_ram.mem[BASE_WORD] !== exp0) begin
      n_mismatched++; $display("FAIL ram_word0: got %h expected %h", u_dut.u_ram.mem[BASE_WORD], exp0);
    end
  endtask

  task automatic test_rdata_flip();
    logic [255:0] flip;
    int n, cycles;
    for (int l = 0; l < 8; l++) flip[32*l +: 32] = 32'hA5A5_0002;
    flip[0] = ~flip[0];
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    n = 0;
    while (!(u_dut.state === ST_R && u_dut.r_beat === 8'd2) && n < DONE_LIMIT) begin
      @(negedge clock);
      n++;
    end
    n_compared++;
    if (u_dut.r_beat !== 8'd2) begin
      n_mismatched++; $display("FAIL flip_reach_beat2: r_beat=%0d expected 2", u_dut.r_beat);
    end
    force u_dut.r_data = flip;
    n = 0;
    while (u_dut.r_beat === 8'd2 && n < DONE_LIMIT) begin
      @(negedge clock);
      n++;
    end
    release u_dut.r_data;
    wait_done(cycles);
    n_compared++;
    if ({done, pass, mismatch_count} !== 7'b10_00001) begin
      n_mismatched++; $display("FAIL flip_result: got done/pass/count %b expected 1000001", {done, pass, mismatch_count});
    end
  endtask

  task automatic test_reset_mid_w();
    int n, cycles;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_compared++;
    if ({done, pass, mismatch_count} !== 7'd0) begin
      n_mismatched++; $display("FAIL async_reset_outputs: got %b expected 0000000", {done, pass, mismatch_count});
    end
    @(negedge clock); reset = 1'b1;
    n = 0;
    while (u_dut.state !== ST_W && n < DONE_LIMIT) begin
      @(negedge clock);
      n++;
    end
    n_compared++;
    if (u_dut.state !== ST_W) begin
      n_mismatched++; $display("FAIL reach_w_phase: state=%0d expected %0d", u_dut.state, ST_W);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_compared++;
    if (u_dut.state !== ST_IDLE || u_dut.w_beat !== 8'd0) begin
      n_mismatched++; $display("FAIL mid_w_abort: state=%0d w_beat=%0d expected 0/0", u_dut.state, u_dut.w_beat);
    end
    n_compared++;
    if ({u_dut.w_valid, u_dut.w_ready, u_dut.aw_ready} !== 3'b000) begin
      n_mismatched++; $display("FAIL mid_w_handshakes: got %b expected 000", {u_dut.w_valid, u_dut.w_ready, u_dut.aw_ready});
    end
    @(negedge clock); reset = 1'b1;
    wait_done(cycles);
    n_compared++;
    if ({done, pass, mismatch_count} !== 7'b11_00000) begin
      n_mismatched++; $display("FAIL restart_result: got %b after %0d cycles expected 1100000", {done, pass, mismatch_count}, cycles);
    end
  endtask

  task automatic test_burst_len1();
    logic [255:0] exp0;
    for (int l = 0; l < 8; l++) exp0[32*l +: 32] = 32'hA5A5_0000;
    n_compared++;
    if ({done1, pass1, count1} !== 7'b11_00000) begin
      n_mismatched++; $display("FAIL len1_result: got %b expected 1100000", {done1, pass1, count1});
    end
    n_compared++;
    if (w1_beats !== 1 || w1_lasts !== 1) begin
      n_mismatched++; $display("FAIL len1_wlast: beats=%0d lasts=%0d expected 1/1", w1_beats, w1_lasts);
    end
    n_compared++;
    if (r1_beats !== 1 || r1_lasts !== 1) begin
      n_mismatched++; $display("FAIL len1_rlast: beats=%0d lasts=%0d expected 1/1", r1_beats, r1_lasts);
    end
    n_compared++;
    if (u_dut1.u_ram.mem[BASE_WORD] !== exp0) begin
      n_mismatched++; $display("FAIL len1_ram_word0: got %h expected %h", u_dut1.u_ram.mem[BASE_WORD], exp0);
    end
  endtask

  task automatic test_protocol();
    n_compared++;
    if (proto_viol !== 0) begin
      n_mismatched++; $display("FAIL protocol: %0d violations expected 0", proto_viol);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ram_probe();
    test_rdata_flip();
    test_reset_mid_w();
    test_burst_len1();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_master_ram_loopback.md
# axi_master_ram_loopback

Self-contained AXI4 loopback block pairing a small test-pattern AXI master with an internal AXI4 RAM slave. After reset it writes one INCR burst to the RAM, reads it back, compares every beat and reports the result on status outputs. It serves as a bring-up and regression fixture for the core's AXI master/slave plumbing and needs no external bus.

## Interface
- DATA_WIDTH, 256, AXI data width in bits (multiple of 32).
- ADDR_WIDTH, 12, AXI byte-address width; the RAM spans 2^ADDR_WIDTH bytes.
- ID_WIDTH, 4, AXI ID width; the master always uses ID 0.
- BURST_LEN, 4, beats per burst (1..16).
- BASE_ADDR, 'h040, burst start byte address, aligned to DATA_WIDTH/8.
- clock  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- done  output  1  high once the readback compare completes; sticky until reset.
- pass  output  1  high with done when all beats matched; sticky.
- mismatch_count  output  5  number of mismatching read beats, saturating at 31.

## Operation
- Master FSM: IDLE -> AW -> W -> B -> AR -> R -> DONE; DONE is terminal.
- IDLE: one cycle after reset deassertion, then AW.
- AW: AWVALID=1, AWADDR=BASE_ADDR, AWLEN=BURST_LEN-1, AWSIZE=log2(DATA_WIDTH/8), AWBURST=INCR. Advance on AWREADY.
- W: beat i carries every 32-bit lane = 32'hA5A5_0000 + i. WSTRB all ones. WLAST on beat BURST_LEN-1. Advance after the last beat's handshake.
- B: BREADY=1. Advance on BVALID. A non-OKAY BRESP counts one mismatch.
- AR: same address fields as AW. Advance on ARREADY.
- R: RREADY=1. Each beat is compared with the expected pattern for its index. A mismatch, non-OKAY RRESP, or RLAST on the wrong beat increments mismatch_count. Advance after the beat with RLAST.
- DONE: done=1; pass = (mismatch_count == 0).
- VALID stays asserted and payload stays stable until the matching READY. VALID never depends combinationally on READY.
- RAM slave handles INCR bursts with one outstanding write and one outstanding read. Writes honour WSTRB. BRESP and RRESP are always OKAY. Memory contents are not reset.

## Timing
- Reset values: all VALID/READY low, done=0, pass=0, mismatch_count=0, FSM=IDLE. Reset asserted mid-transaction aborts it immediately and the sequence restarts after release.
- Slave AWREADY/ARREADY are high when the slave is idle. The address handshake takes 1 cycle. The slave drops READY while a burst is active.
- Slave WREADY is high on the cycle after the AW handshake. BVALID comes 1 cycle after the WLAST handshake.
- RVALID comes 1 cycle after the AR handshake, then one beat per cycle while RREADY=1.
- Without backpressure: done rises no later than 20 cycles after reset release. With backpressure: no later than 40 cycles.
- A read of a not-yet-written word returns X in simulation. The sequence never issues such a read.

## Configuration
- AXI_LOOPBACK_BACKPRESSURE_EN defined: the slave's WREADY and RVALID toggle every cycle during a burst (asserted on even beat cycles). This exercises stall handling; results must be identical.
- Macro undefined: full-throughput behaviour as specified above.

## Structure
- Shared package axi_loopback_pkg holds:
  - AXI burst/resp encodings (INCR=2'b01, OKAY=2'b00);
  - the FSM state enum;
  - the pattern constant 32'hA5A5_0000;
  - AW/W/B/AR/R channel struct typedefs parameterised by the widths.
- Top level contains the master FSM and compare logic.
- One sub-module, axi_loopback_ram, implements the AXI4 RAM slave.

## Test plan
- Default params, reset released at 20 ns -> done=1, pass=1, mismatch_count=0 within 20 cycles; stays stable to 1000 ns.
- Probe the RAM after done -> word at BASE_ADDR/32 + 3 has every lane 32'hA5A5_0003.
- Force one RDATA bit flip on beat 2 -> done=1, pass=0, mismatch_count=1.
- Assert reset during the W phase, then release -> outputs return to 0 immediately; full pass after the restart.
- Compile with AXI_LOOPBACK_BACKPRESSURE_EN -> pass=1 within 40 cycles; a protocol checker reports no VALID drop before READY.
- BURST_LEN=1 -> single beat with WLAST=RLAST on beat 0; pass=1.
